// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator, valid/ready in and out.
// Decodes instr[31:7] by immsrc into an XLEN immediate, STAGES deep, tag passed through.
//   clk, rst        clock, synchronous active-high reset
//   flush           drop every in-flight entry and any request this cycle
//   in_valid/ready  request handshake; instr[31:7], immsrc, in_tag sampled on transfer
//   out_valid/ready result handshake; imm, imm_err, out_tag held while stalled
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic             imm_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_B  = 3'd2;
  localparam logic [2:0] IMM_J  = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;
  localparam logic [2:0] IMM_Z  = 3'd5;
  localparam logic [2:0] IMM_SH = 3'd6;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be 1 or 2");
  end

  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic             err;
    logic [TAG_W-1:0] tag;
  } ent_t;

  // Index the field with real instruction bit numbers.
  logic [31:7] ir;
  assign ir = instr;

  ent_t dec;

  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    // Sign fill first; each format overwrites its low bits.
    dec.val = {XLEN{ir[31]}};
    unique case (immsrc)
      IMM_I:  dec.val[11:0] = ir[31:20];
      IMM_S:  dec.val[11:0] = {ir[31:25], ir[11:7]};
      IMM_B:  dec.val[12:0] = {ir[31], ir[7], ir[30:25],
                               ir[11:8], 1'b0};
      IMM_J:  dec.val[20:0] = {ir[31], ir[19:12], ir[20],
                               ir[30:21], 1'b0};
      IMM_U:  dec.val[31:0] = {ir[31:12], 12'b0};
      IMM_Z: begin
        dec.val      = '0;
        dec.val[4:0] = ir[19:15];
      end
      IMM_SH: begin
        dec.val      = '0;
        dec.val[4:0] = ir[24:20];
        if (XLEN == 64) dec.val[5] = ir[25];
      end
      default: begin
        dec.val = '0;
        dec.err = 1'b1;
      end
    endcase
  end

  logic [STAGES-1:0] v_q, v_d, mv, ld;
  ent_t              e_q [STAGES];
  ent_t              e_d [STAGES];

  always_comb begin
    mv = '0;
    ld = '0;
    // A stage moves when its successor is empty or itself
    // moves; this also collapses bubbles ahead of a stall.
    mv[STAGES-1] = v_q[STAGES-1] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      mv[k] = v_q[k] & (~v_q[k+1] | mv[k+1]);
    end
    in_ready = ~rst & (flush | ~v_q[0] | mv[0]);
    ld[0] = in_valid & in_ready & ~flush;
    for (int k = 1; k < STAGES; k++) begin
      ld[k] = mv[k-1] & ~flush;
    end
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = ld[k] | (v_q[k] & ~mv[k]);
    end
    if (flush) v_d = '0;
    e_d[0] = ld[0] ? dec : e_q[0];
    for (int k = 1; k < STAGES; k++) begin
      e_d[k] = ld[k] ? e_q[k-1] : e_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) e_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) e_q[k] <= e_d[k];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign imm       = e_q[STAGES-1].val;
  assign imm_err   = e_q[STAGES-1].err;
  assign out_tag   = e_q[STAGES-1].tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors, corner sequences and random traffic
// against two builds of imm_gen_pipe (XLEN=32/STAGES=1 and XLEN=64/STAGES=2).
module tb_imm_gen_pipe;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_B  = 3'd2;
  localparam logic [2:0] IMM_J  = 3'd3;
  localparam logic [2:0] IMM_U  = 3'd4;
  localparam logic [2:0] IMM_Z  = 3'd5;
  localparam logic [2:0] IMM_SH = 3'd6;
  localparam logic [2:0] IMM_RS = 3'd7;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  immsrc;
  logic [3:0]  in_tag;

  logic        ir_a, ov_a, er_a;
  logic [31:0] imm_a;
  logic [3:0]  tg_a;
  logic        ir_b, ov_b, er_b;
  logic [63:0] imm_b;
  logic [3:0]  tg_b;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_a),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(ov_a), .out_ready(out_ready),
    .imm(imm_a), .imm_err(er_a), .out_tag(tg_a)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2), .TAG_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir_b),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(ov_b), .out_ready(out_ready),
    .imm(imm_b), .imm_err(er_b), .out_tag(tg_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit last_rst;

  typedef struct {
    logic [63:0] val;
    logic        err;
    logic [3:0]  tag;
    int          acc;
  } sb_t;

  sb_t q [2][$];

  typedef struct {
    logic [31:0] w;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference: immediate value from its arithmetic meaning.
  function automatic logic [64:0] ref_imm(logic [31:0] w,
                                          logic [2:0] src, bit x64);
    longint sx = longint'(signed'(w));
    longint v  = 0;
    bit     e  = 1'b0;
    case (src)
      IMM_I: v = sx >>> 20;
      IMM_S: v = ((sx >>> 25) <<< 5) | longint'(w[11:7]);
      IMM_B: v = ((sx >>> 31) <<< 12) | (longint'(w[7]) << 11)
               | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
      IMM_J: v = ((sx >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
               | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
      IMM_U: v = sx & 64'hFFFF_FFFF_FFFF_F000;
      IMM_Z: v = longint'(w[19:15]);
      IMM_SH: v = x64 ? longint'(w[25:20]) : longint'(w[24:20]);
      default: begin
        v = 0;
        e = 1'b1;
      end
    endcase
    if (!x64) v = v & 64'h0000_0000_FFFF_FFFF;
    return {e, v};
  endfunction

  // Per-cycle model: entries in accept order; an entry is visible
  // STAGES cycles after acceptance, and at most STAGES in flight.
  task automatic sb(int d, logic ov, logic ir, logic [63:0] im,
                    logic er, logic [3:0] tg);
    int         stg = (d == 0) ? 1 : 2;
    string      nm  = (d == 0) ? "A" : "B";
    bit         vis, eir;
    logic [64:0] r;
    if (last_rst) begin
      chk({nm, ".rst_imm"}, im, 64'd0);
      chk({nm, ".rst_err_tag"}, {59'd0, er, tg}, 64'd0);
    end
    vis = (q[d].size() > 0) && (cyc >= q[d][0].acc + stg);
    chk({nm, ".out_valid"}, {63'd0, ov}, {63'd0, vis});
    if (vis && ov) begin
      chk({nm, ".imm"}, im, q[d][0].val);
      chk({nm, ".err_tag"}, {59'd0, er, tg},
          {59'd0, q[d][0].err, q[d][0].tag});
    end
    if (rst) eir = 1'b0;
    else if (flush) eir = 1'b1;
    else eir = !(q[d].size() >= stg && !out_ready);
    chk({nm, ".in_ready"}, {63'd0, ir}, {63'd0, eir});
    if (rst || flush) begin
      q[d].delete();
    end else begin
      if (vis && out_ready) void'(q[d].pop_front());
      if (in_valid && eir) begin
        r = ref_imm({instr, 7'd0}, immsrc, d == 1);
        q[d].push_back('{val: r[63:0], err: r[64],
                         tag: in_tag, acc: cyc});
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb(0, ov_a, ir_a, {32'd0, imm_a}, er_a, tg_a);
    sb(1, ov_b, ir_b, imm_b, er_b, tg_b);
    @(posedge clk);
    last_rst = rst;
    cyc++;
    #1;
  endtask

  task automatic drive(logic [31:0] w, logic [2:0] s, logic [3:0] t);
    in_valid = 1'b1;
    instr    = w[31:7];
    immsrc   = s;
    in_tag   = t;
  endtask

  vec_t vecs [12];
  int   got [$];
  int   seen;

  initial begin
    vecs[0]  = '{32'hFFF00093, IMM_I,  32'hFFFFFFFF,
                 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[1]  = '{32'hFE000EE3, IMM_B,  32'hFFFFFFFC,
                 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[2]  = '{32'h12345037, IMM_U,  32'h12345000,
                 64'h00000000_12345000, 1'b0};
    vecs[3]  = '{32'h000F8073, IMM_Z,  32'h0000001F,
                 64'h00000000_0000001F, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, IMM_RS, 32'h00000000,
                 64'h00000000_00000000, 1'b1};
    vecs[5]  = '{32'h03F00013, IMM_SH, 32'h0000001F,
                 64'h00000000_0000003F, 1'b0};
    vecs[6]  = '{32'h80000037, IMM_U,  32'h80000000,
                 64'hFFFFFFFF_80000000, 1'b0};
    vecs[7]  = '{32'hFE000C23, IMM_S,  32'hFFFFFFF8,
                 64'hFFFFFFFF_FFFFFFF8, 1'b0};
    vecs[8]  = '{32'h0010006F, IMM_J,  32'h00000800,
                 64'h00000000_00000800, 1'b0};
    vecs[9]  = '{32'h7FF00093, IMM_I,  32'h000007FF,
                 64'h00000000_000007FF, 1'b0};
    vecs[10] = '{32'h00000463, IMM_B,  32'h00000008,
                 64'h00000000_00000008, 1'b0};
    vecs[11] = '{32'h8000006F, IMM_J,  32'hFFF00000,
                 64'hFFFFFFFF_FFF00000, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; immsrc = '0; in_tag = '0;
    @(posedge clk);
    last_rst = 1'b1;
    cyc = 1;
    #1;
    cycle();
    chk("rst_in_ready", {63'd0, ir_a, ir_b}, 64'd0);
    chk("rst_out_valid", {63'd0, ov_a, ov_b}, 64'd0);
    chk("rst_imm_b", imm_b, 64'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", {62'd0, ir_a, ir_b}, 64'd3);

    foreach (vecs[i]) begin
      drive(vecs[i].w, vecs[i].src, 4'(i));
      cycle();
      in_valid = 1'b0;
      chk("vecA_valid", {63'd0, ov_a}, 64'd1);
      chk("vecA_imm", {32'd0, imm_a}, {32'd0, vecs[i].e32});
      chk("vecA_err", {63'd0, er_a}, {63'd0, vecs[i].err});
      cycle();
      chk("vecB_valid", {62'd0, ov_a, ov_b}, 64'd1);
      chk("vecB_imm", imm_b, vecs[i].e64);
      chk("vecB_err", {63'd0, er_b}, {63'd0, vecs[i].err});
      cycle();
    end

    // Backpressure: two entries fill STAGES=2, third waits.
    out_ready = 1'b0;
    drive(32'h00100093, IMM_I, 4'd1); #1;
    chk("bp_ready1", {63'd0, ir_b}, 64'd1);
    cycle();
    drive(32'h00200093, IMM_I, 4'd2); #1;
    chk("bp_ready2", {63'd0, ir_b}, 64'd1);
    cycle();
    drive(32'h00300093, IMM_I, 4'd3); #1;
    chk("bp_ready3", {63'd0, ir_b}, 64'd0);
    cycle();
    chk("bp_hold1", {59'd0, ov_b, tg_b}, {59'd0, 1'b1, 4'd1});
    cycle();
    chk("bp_hold2", {59'd0, ov_b, tg_b}, {59'd0, 1'b1, 4'd1});
    chk("bp_hold_imm", imm_b, 64'd1);
    out_ready = 1'b1; #1;
    chk("bp_release_ready", {63'd0, ir_b}, 64'd1);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (ov_b) got.push_back(int'(tg_b));
      cycle();
      in_valid = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3)
      chk("bp_order", {52'd0, 4'(got[0]), 4'(got[1]), 4'(got[2])},
          {52'd0, 12'h123});

    // Flush with two entries in flight and a request present.
    out_ready = 1'b0;
    drive(32'h00400093, IMM_I, 4'd4); cycle();
    drive(32'h00500093, IMM_I, 4'd5); cycle();
    drive(32'h00600093, IMM_I, 4'd6); flush = 1'b1; #1;
    chk("fl_ready", {62'd0, ir_a, ir_b}, 64'd3);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", {62'd0, ov_a, ov_b}, 64'd0);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (ov_a || ov_b) seen++;
    end
    chk("fl_no_result", 64'(seen), 64'd0);

    // Reset with an entry visible at the output.
    out_ready = 1'b0;
    drive(32'hFFF00093, IMM_I, 4'd7); cycle();
    in_valid = 1'b0; cycle();
    chk("rs_pre_valid", {63'd0, ov_b}, 64'd1);
    rst = 1'b1; #1;
    chk("rs_ready_low", {62'd0, ir_a, ir_b}, 64'd0);
    cycle();
    chk("rs_valid", {62'd0, ov_a, ov_b}, 64'd0);
    chk("rs_imm", imm_b, 64'd0);
    rst = 1'b0;
    cycle();
    chk("rs_ready_after", {62'd0, ir_a, ir_b}, 64'd3);

    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(39) == 0);
      rst       = ($urandom_range(299) == 0);
      instr     = 25'($urandom);
      immsrc    = 3'($urandom_range(7));
      in_tag    = 4'($urandom);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", 64'(q[0].size() + q[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
